logic_axi4_lite_queue: RTL

//  AXI4-Lite pipeline stage between an upstream master (slave port) and a downstream slave (master port).

---
 rtl/logic_axi4_lite_queue_if.sv | 50 +++++
 rtl/logic_axi4_lite_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_lite_queue_if.sv
// AXI4-Lite bundle shared by both sides of the queue.
// Every channel uses the same handshake: a beat transfers on a rising aclk edge
// where valid and ready are both high; once valid is raised it stays high with a
// stable payload until that transfer, and valid never waits on ready.
interface logic_axi4_lite_if #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDRESS_WIDTH = 1
);
    logic                       awvalid;
    logic                       awready;
    logic [ADDRESS_WIDTH-1:0]   awaddr;
    logic [2:0]                 awprot;

    logic                       wvalid;
    logic                       wready;
    logic [8*DATA_BYTES-1:0]    wdata;
    logic [DATA_BYTES-1:0]      wstrb;

    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;

    logic                       arvalid;
    logic                       arready;
    logic [ADDRESS_WIDTH-1:0]   araddr;
    logic [2:0]                 arprot;

    logic                       rvalid;
    logic                       rready;
    logic [8*DATA_BYTES-1:0]    rdata;
    logic [1:0]                 rresp;

    // Seen from the component that receives requests (faces an upstream master).
    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb,    output wready,
        output bvalid, bresp,           input  bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp,    input  rready
    );

    // Seen from the component that issues requests (faces a downstream slave).
    modport master (
        output awvalid, awaddr, awprot, input  awready,
        output wvalid, wdata, wstrb,    input  wready,
        input  bvalid, bresp,           output bready,
        output arvalid, araddr, arprot, input  arready,
        input  rvalid, rdata, rresp,    output rready
    );
endinterface

// File: rtl/logic_axi4_lite_queue.sv
// AXI4-Lite pipeline stage: one configurable queue per channel plus optional
// outstanding-transaction limiters on the write and read paths.

// One channel: DEPTH = 0 is a wire, DEPTH >= 1 is a first-word fall-through
// circular FIFO whose rx ready is a flop, so upstream ready never depends
// combinationally on downstream ready.
module logic_axi4_lite_queue_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    input  logic [WIDTH-1:0] rx_data_i,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [WIDTH-1:0] tx_data_o,
    output logic             empty_o
);
    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = aclk ^ areset;

        assign tx_valid_o = rx_valid_i;
        assign tx_data_o  = rx_data_i;
        assign rx_ready_o = tx_ready_i;
        assign empty_o    = 1'b1;
    end else begin : g_fifo
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int LW = $clog2(DEPTH + 1);

        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [LW-1:0]    level_q, level_d;
        logic             ready_q, ready_d;
        logic             push, pop;

        assign push       = rx_valid_i & ready_q;
        assign pop        = tx_valid_o & tx_ready_i;
        assign tx_valid_o = (level_q != '0);
        assign tx_data_o  = mem_q[rd_ptr_q];
        assign rx_ready_o = ready_q;
        assign empty_o    = (level_q == '0);

        // Next pointers, level and ready; pointers wrap at DEPTH-1 so any depth works.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            level_d  = level_q;
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
            // Ready tracks the level being entered, so a full FIFO is never offered a beat.
            ready_d = (level_d != LW'(DEPTH));
        end

        // Pointer, level and ready registers; ready stays low through reset.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                ready_q  <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                level_q  <= level_d;
                ready_q  <= ready_d;
            end
        end

        // Storage is cleared on reset so the idle payload is a known value.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (push) begin
                mem_q[wr_ptr_q] <= rx_data_i;
            end
        end
    end
endmodule

// Top: five channel queues between the upstream and downstream AXI4-Lite ports.
module logic_axi4_lite_queue #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDRESS_WIDTH = 1,
    parameter int AW_DEPTH      = 2,
    parameter int W_DEPTH       = 2,
    parameter int B_DEPTH       = 0,
    parameter int AR_DEPTH      = 2,
    parameter int R_DEPTH       = 0,
    parameter int MAX_WRITES    = 0,
    parameter int MAX_READS     = 0,
    localparam int CW = (MAX_WRITES > 0) ? $clog2(MAX_WRITES + 1) : 1,
    localparam int CR = (MAX_READS > 0) ? $clog2(MAX_READS + 1) : 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    logic_axi4_lite_if.slave      slave,
    logic_axi4_lite_if.master     master,
    output logic [CW-1:0]         write_outstanding,
    output logic [CR-1:0]         read_outstanding,
    output logic                  idle
);
    localparam int DW  = 8 * DATA_BYTES;
    localparam int AXW = 3 + ADDRESS_WIDTH;
    localparam int WW  = DATA_BYTES + DW;
    localparam int RW  = 2 + DW;

    logic           aw_rx_ready, ar_rx_ready;
    logic           w_block, r_block;
    logic           aw_empty, w_empty, b_empty, ar_empty, r_empty;
    logic [AXW-1:0] aw_tx_data, ar_tx_data;
    logic [WW-1:0]  w_tx_data;
    logic [1:0]     b_tx_data;
    logic [RW-1:0]  r_tx_data;

    // The limiter blocks both sides of the slave AW/AR handshake, so a pass-through
    // channel never forwards a beat the slave side has not accepted.
    assign slave.awready = aw_rx_ready & ~w_block;
    assign slave.arready = ar_rx_ready & ~r_block;

    assign {master.awprot, master.awaddr} = aw_tx_data;
    assign {master.wstrb, master.wdata}   = w_tx_data;
    assign slave.bresp                    = b_tx_data;
    assign {master.arprot, master.araddr} = ar_tx_data;
    assign {slave.rresp, slave.rdata}     = r_tx_data;

    logic_axi4_lite_queue_fifo #(.WIDTH(AXW), .DEPTH(AW_DEPTH)) u_aw (
        .aclk       (aclk),
        .areset     (areset),
        .rx_valid_i (slave.awvalid & ~w_block),
        .rx_ready_o (aw_rx_ready),
        .rx_data_i  ({slave.awprot, slave.awaddr}),
        .tx_valid_o (master.awvalid),
        .tx_ready_i (master.awready),
        .tx_data_o  (aw_tx_data),
        .empty_o    (aw_empty)
    );

    logic_axi4_lite_queue_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w (
        .aclk       (aclk),
        .areset     (areset),
        .rx_valid_i (slave.wvalid),
        .rx_ready_o (slave.wready),
        .rx_data_i  ({slave.wstrb, slave.wdata}),
        .tx_valid_o (master.wvalid),
        .tx_ready_i (master.wready),
        .tx_data_o  (w_tx_data),
        .empty_o    (w_empty)
    );

    logic_axi4_lite_queue_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b (
        .aclk       (aclk),
        .areset     (areset),
        .rx_valid_i (master.bvalid),
        .rx_ready_o (master.bready),
        .rx_data_i  (master.bresp),
        .tx_valid_o (slave.bvalid),
        .tx_ready_i (slave.bready),
        .tx_data_o  (b_tx_data),
        .empty_o    (b_empty)
    );

    logic_axi4_lite_queue_fifo #(.WIDTH(AXW), .DEPTH(AR_DEPTH)) u_ar (
        .aclk       (aclk),
        .areset     (areset),
        .rx_valid_i (slave.arvalid & ~r_block),
        .rx_ready_o (ar_rx_ready),
        .rx_data_i  ({slave.arprot, slave.araddr}),
        .tx_valid_o (master.arvalid),
        .tx_ready_i (master.arready),
        .tx_data_o  (ar_tx_data),
        .empty_o    (ar_empty)
    );

    logic_axi4_lite_queue_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH)) u_r (
        .aclk       (aclk),
        .areset     (areset),
        .rx_valid_i (master.rvalid),
        .rx_ready_o (master.rready),
        .rx_data_i  ({master.rresp, master.rdata}),
        .tx_valid_o (slave.rvalid),
        .tx_ready_i (slave.rready),
        .tx_data_o  (r_tx_data),
        .empty_o    (r_empty)
    );

    if (MAX_WRITES > 0) begin : g_wr_limit
        logic [CW-1:0] cnt_q, cnt_d;
        logic          inc, dec;

        assign inc = slave.awvalid & slave.awready;
        assign dec = slave.bvalid & slave.bready;

        // Outstanding writes: +1 per accepted AW, -1 per returned B, held at 0 on underflow.
        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + CW'(1);
            end else if (dec && !inc && cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // Write counter register; a B with nothing outstanding is a protocol error.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                cnt_q <= '0;
            end else begin
                assert (!(dec && cnt_q == '0))
                    else $error("write response returned with no write outstanding");
                cnt_q <= cnt_d;
            end
        end

        assign w_block           = (cnt_q == CW'(MAX_WRITES));
        assign write_outstanding = cnt_q;
    end else begin : g_wr_free
        assign w_block           = 1'b0;
        assign write_outstanding = '0;
    end

    if (MAX_READS > 0) begin : g_rd_limit
        logic [CR-1:0] cnt_q, cnt_d;
        logic          inc, dec;

        assign inc = slave.arvalid & slave.arready;
        assign dec = slave.rvalid & slave.rready;

        // Outstanding reads: +1 per accepted AR, -1 per returned R, held at 0 on underflow.
        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + CR'(1);
            end else if (dec && !inc && cnt_q != '0) begin
                cnt_d = cnt_q - CR'(1);
            end
        end

        // Read counter register; an R with nothing outstanding is a protocol error.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                cnt_q <= '0;
            end else begin
                assert (!(dec && cnt_q == '0))
                    else $error("read response returned with no read outstanding");
                cnt_q <= cnt_d;
            end
        end

        assign r_block          = (cnt_q == CR'(MAX_READS));
        assign read_outstanding = cnt_q;
    end else begin : g_rd_free
        assign r_block          = 1'b0;
        assign read_outstanding = '0;
    end

    assign idle = aw_empty & w_empty & b_empty & ar_empty & r_empty
                & (write_outstanding == '0) & (read_outstanding == '0);
endmodule
